// File: rtl/fifo_sync_param_if.sv
// Producer/consumer bundle for fifo_sync_param: write side, read side, status and error flags.
// The FIFO takes the slave modport; the block driving wen/ren takes the master modport.
interface fifo_sync_param_if #(
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 4
);
    logic               wen;
    logic [D_WIDTH-1:0] wdata;
    logic               ren;
    logic               err_clr;
    logic [D_WIDTH-1:0] rdata;
    logic               rvalid;
    logic               full;
    logic               empty;
    logic               almost_full;
    logic               almost_empty;
    logic [A_WIDTH:0]   count;
    logic               overflow;
    logic               underflow;

    modport master (
        output wen, wdata, ren, err_clr,
        input  rdata, rvalid, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wen, wdata, ren, err_clr,
        output rdata, rvalid, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO on a register-array memory with registered read data.
// Define FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags (cleared by err_clr).
module fifo_sync_param #(
    parameter int D_WIDTH  = 8,
    parameter int A_WIDTH  = 4,
    parameter int AF_LEVEL = 2 ** A_WIDTH - 2,
    parameter int AE_LEVEL = 2
) (
    input logic              clk,
    input logic              rst_n,
    fifo_sync_param_if.slave bus
);
    localparam int DEPTH = 2 ** A_WIDTH;
    localparam logic [A_WIDTH:0] DEPTH_C = (A_WIDTH + 1)'(DEPTH);
    localparam logic [A_WIDTH:0] AF_C    = (A_WIDTH + 1)'(AF_LEVEL);
    localparam logic [A_WIDTH:0] AE_C    = (A_WIDTH + 1)'(AE_LEVEL);

    logic [D_WIDTH-1:0] mem [DEPTH];
    logic [A_WIDTH:0]   wr_ptr;
    logic [A_WIDTH:0]   rd_ptr;
    logic [A_WIDTH:0]   count_q;
    logic [D_WIDTH-1:0] rdata_q;
    logic               rvalid_q;
    logic               full_w;
    logic               empty_w;
    logic               wr_accept;
    logic               rd_accept;

    // Status is decoded purely from the registered count, so wen/ren never reach an output.
    assign full_w    = (count_q == DEPTH_C);
    assign empty_w   = (count_q == '0);
    assign wr_accept = bus.wen && !full_w;
    assign rd_accept = bus.ren && !empty_w;

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr[A_WIDTH-1:0]] <= bus.wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_accept) begin
                rdata_q <= mem[rd_ptr[A_WIDTH-1:0]];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            rvalid_q <= rd_accept;
            case ({wr_accept, rd_accept})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    // A fresh error wins over err_clr in the same cycle so no event is ever lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.wen && full_w) begin
                overflow_q <= 1'b1;
            end else if (bus.err_clr) begin
                overflow_q <= 1'b0;
            end
            if (bus.ren && empty_w) begin
                underflow_q <= 1'b1;
            end else if (bus.err_clr) begin
                underflow_q <= 1'b0;
            end
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = bus.err_clr;
    assign bus.overflow   = 1'b0;
    assign bus.underflow  = 1'b0;
`endif

    assign bus.rdata        = rdata_q;
    assign bus.rvalid       = rvalid_q;
    assign bus.count        = count_q;
    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (count_q >= AF_C);
    assign bus.almost_empty = (count_q <= AE_C);
endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised single-clock synchronous FIFO built on a simple dual-port register-array memory with registered read data. It generalises the fixed 16x8 dual-port RAM into a buffered stream element: width and depth are parameters, and it adds write/read pointer management, an occupancy count, full/empty and programmable almost-full/almost-empty flags, and optional sticky error flags. It sits between a producer and a consumer on the same clock, as the standard rate-decoupling buffer for the lab memory datapaths.

## Interface
- D_WIDTH, 8, data word width in bits
- A_WIDTH, 4, address width; DEPTH = 2**A_WIDTH words
- AF_LEVEL, 2**A_WIDTH-2, almost_full asserts when count >= AF_LEVEL
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL
- clk  input  1  clock, all state updates on posedge
- rst_n  input  1  reset, asynchronous, active-low
- wen  input  1  write request
- wdata  input  D_WIDTH  write data
- ren  input  1  read request
- rdata  output  D_WIDTH  read data, registered
- rvalid  output  1  rdata holds a newly popped word this cycle
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count >= AF_LEVEL
- almost_empty  output  1  count <= AE_LEVEL
- count  output  A_WIDTH+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: write attempted while full
- underflow  output  1  sticky: read attempted while empty
- err_clr  input  1  synchronous clear of overflow/underflow

## Operation
- Storage: DEPTH x D_WIDTH array, written at wr_ptr, read at rd_ptr; no reset of array contents.
- Pointers: A_WIDTH+1 bits; low A_WIDTH bits address the array; natural binary wrap DEPTH-1 -> 0.
- Write accepted iff wen && !full (flags sampled before the edge): array[wr_ptr] <= wdata, wr_ptr += 1.
- Read accepted iff ren && !empty: rdata <= array[rd_ptr], rd_ptr += 1, rvalid <= 1; otherwise rvalid <= 0 and rdata holds previous value.
- count: +1 on write-only accept, -1 on read-only accept, unchanged on both or neither.
- Simultaneous wen && ren: when full, only read accepted (count DEPTH -> DEPTH-1); when empty, only write accepted (count 0 -> 1); otherwise both accepted, count unchanged.
- Read and write never target the same live entry in one cycle (equal pointers imply full or empty, which blocks one side); no bypass logic.
- Flags are decoded from registered count; no combinational path from wen/ren to any output.
- Rejected requests change no state other than the error flags.
- Parameter legality: 1 <= AE_LEVEL < AF_LEVEL <= DEPTH; A_WIDTH >= 1.

## Timing
- Reset (rst_n low, asynchronous): wr_ptr = rd_ptr = 0, count = 0, rdata = 0, rvalid = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0, overflow = 0, underflow = 0.
- Reset asserted mid-operation discards all contents immediately; deassertion takes effect at next posedge.
- Write-to-flag latency: 1 cycle (count/empty update on the accepting edge).
- Write-to-read: a word written on edge N is readable by a ren sampled at edge N+1; appears on rdata after edge N+1 with rvalid = 1.
- Read latency: 1 cycle, ren at edge N -> rdata/rvalid valid after edge N.
- Back-to-back reads sustain one word per cycle; throughput one write and one read per cycle.

## Configuration
- FIFO_ERR_FLAGS_EN defined: overflow sets on wen && full, underflow sets on ren && empty; both stay set until err_clr or reset; err_clr and a new error in the same cycle leave the flag set.
- Not defined: overflow and underflow are constant 0, err_clr ignored; no error-flag registers synthesised.

## Test plan
- Reset: hold rst_n low mid-stream with count = 5 -> count = 0, empty = 1, rvalid = 0, rdata = 0 asynchronously.
- Fill/drain (8x16): write 0x00..0x0F -> full = 1, count = 16, almost_full from count 14; read 16 -> rdata 0x00..0x0F in order, one cycle after each ren, empty = 1 at end.
- Overflow/underflow (macro on): 17th write 0xAA while full -> discarded, overflow = 1, count stays 16; read on empty -> underflow = 1, rvalid = 0; err_clr -> both 0. Macro off -> both stay 0.
- Simultaneous: at count = 5 assert wen+ren 10 cycles -> count stays 5, data order preserved; at full, wen+ren -> count 15; at empty, wen+ren -> count 1, rvalid = 0.
- Wrap-around: 40 interleaved writes/reads keeping count 3..7 -> pointers wrap twice, every read matches the written sequence.
- Thresholds: AF_LEVEL = 12, AE_LEVEL = 4 -> almost_full toggles exactly at 11<->12, almost_empty at 4<->5.
